// File: rtl/conv_tree_serializer_16.sv
// conv_tree_serializer_16
// Serializes a 16-bit word at two bits per clock period (one per clock phase).
// The word arrives in tree (bit-reversed) order. A 3-bit phase counter steers
// a 4-level tree of 2:1 muxes. The last mux is switched by the CLK level
// itself: the high half of each period reads the L[0..7] path and the low
// half reads the L[8..15] path.
// A new word is captured on the rising edge where the counter wraps 7->0.
// That same edge starts the first slot of the new frame, so frames run
// back-to-back with no idle slots.
module conv_tree_serializer_16 (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] PAR_IN,
  output logic        SERIAL_OUT
);

  logic [2:0]  cnt_q;
  logic [2:0]  cnt_d;
  logic [15:0] load_q;
  logic [15:0] load_d;

  logic [7:0]  lvl1;
  logic [3:0]  lvl2;
  logic [1:0]  lvl3;

  // Next state: the counter is free-running; the word is captured only when cnt wraps.
  always_comb begin
    cnt_d  = cnt_q + 3'd1;
    load_d = load_q;
    if (cnt_q == 3'd7) begin
      load_d = PAR_IN;
    end
  end

  // State registers; synchronous reset clears the counter and the word, which forces the output to 0.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q  <= 3'd0;
      load_q <= 16'd0;
    end else begin
      cnt_q  <= cnt_d;
      load_q <= load_d;
    end
  end

  // Mux tree levels 1-3: cnt[2] picks the odd/even pair (index bit 0), cnt[1] picks index bit 1, cnt[0] picks index bit 2.
  always_comb begin
    lvl1 = '0;
    lvl2 = '0;
    lvl3 = '0;
    for (int j = 0; j < 8; j++) begin
      lvl1[j] = cnt_q[2] ? load_q[2*j+1] : load_q[2*j];
    end
    for (int k = 0; k < 4; k++) begin
      lvl2[k] = cnt_q[1] ? lvl1[2*k+1] : lvl1[2*k];
    end
    for (int m = 0; m < 2; m++) begin
      lvl3[m] = cnt_q[0] ? lvl2[2*m+1] : lvl2[2*m];
    end
  end

  // Final mux (index bit 3): the CLK level picks the slot within the period, so the output changes on both phases.
  assign SERIAL_OUT = CLK ? lvl3[0] : lvl3[1];

endmodule

// File: tb/tb_conv_tree_serializer_16.sv
// Testbench for conv_tree_serializer_16.
// Reference model: a phase count 0..7 and the word last loaded. The expected
// bit in slot n = 2*cnt + h is word[bitrev4(n)].
module tb_conv_tree_serializer_16;

  logic        CLK;
  logic        RESET;
  logic [15:0] PAR_IN;
  logic        SERIAL_OUT;

  int          n_checks = 0;
  int          n_fail   = 0;

  // reference model state
  int          m_cnt  = 0;
  logic [15:0] m_word = '0;
  logic [15:0] obs_frame = '0;

  conv_tree_serializer_16 dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .PAR_IN     (PAR_IN),
    .SERIAL_OUT (SERIAL_OUT)
  );

  // clock / reset defaults
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [3:0] bitrev4(input logic [3:0] n);
    return {n[0], n[1], n[2], n[3]};
  endfunction

  // Place data word d so that it streams out d[0] first.
  function automatic logic [15:0] tree_order(input logic [15:0] d);
    logic [15:0] p;
    for (int i = 0; i < 16; i++) begin
      p[i] = d[bitrev4(4'(i))];
    end
    return p;
  endfunction

  task automatic check_slot(input int h, input string tag);
    logic [3:0] n;
    logic       exp;
    n   = 4'(2 * m_cnt + h);
    exp = m_word[bitrev4(n)];
    obs_frame[n] = SERIAL_OUT;
    n_checks++;
    assert (SERIAL_OUT === exp) else begin
      n_fail++;
      $error("FAIL %s slot=%0d observed=%b expected=%b", tag, n, SERIAL_OUT, exp);
    end
  endtask

  // Drive one CLK period and check both of its slots.
  task automatic run_period(input logic [15:0] par, input logic rst, input string tag);
    PAR_IN = par;
    RESET  = rst;
    @(posedge CLK);
    if (rst) begin
      m_cnt  = 0;
      m_word = '0;
    end else begin
      if (m_cnt == 7) m_word = par;
      m_cnt = (m_cnt + 1) % 8;
    end
    #2;
    check_slot(0, tag);
    @(negedge CLK);
    #2;
    check_slot(1, tag);
  endtask

  task automatic check_frame(input logic [15:0] exp, input string tag);
    n_checks++;
    assert (obs_frame === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs_frame, exp);
    end
  endtask

  // directed and random stimulus
  initial begin
    logic [15:0] w;
    logic [15:0] par_c5af;
    RESET  = 1'b1;
    PAR_IN = '0;

    // held reset: output stays 0
    for (int i = 0; i < 4; i++) run_period(16'hFFFF, 1'b1, "reset_hold");

    // single-bit words: slot 0, slot 1 and slot 15
    for (int i = 0; i < 24; i++) run_period(16'h0001, 1'b0, "word_0001");
    for (int i = 0; i < 24; i++) run_period(16'h0100, 1'b0, "word_0100");
    for (int i = 0; i < 24; i++) run_period(16'h8000, 1'b0, "word_8000");

    // D = C5AF placed in tree order (works out to D5B3); stream must read D[0..15]
    par_c5af = tree_order(16'hC5AF);
    while (m_cnt != 7) run_period(par_c5af, 1'b0, "c5af_align");
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 8; i++) run_period(par_c5af, 1'b0, "c5af_slot");
      check_frame(16'hC5AF, "c5af_frame");
    end

    // input change mid-frame has no effect until the next load
    while (m_cnt != 2) run_period(16'hFFFF, 1'b0, "ffff_run");
    for (int i = 0; i < 16; i++) run_period(16'h0000, 1'b0, "mid_change");

    // reset pulse mid-frame
    for (int i = 0; i < 12; i++) run_period(16'hFFFF, 1'b0, "pre_pulse");
    run_period(16'hFFFF, 1'b1, "reset_pulse");
    for (int i = 0; i < 7; i++) begin
      run_period(16'hFFFF, 1'b0, "post_pulse_zero");
    end
    for (int i = 0; i < 8; i++) run_period(16'hFFFF, 1'b0, "post_pulse_ones");
    check_frame(16'hFFFF, "post_pulse_frame");

    // random sweep
    for (int k = 0; k < 10; k++) begin
      w = 16'($urandom_range(0, 16'hFFFF));
      for (int i = 0; i < 21; i++) run_period(w, 1'b0, "rand_word");
      for (int i = 0; i < 7; i++) run_period(16'h0000, 1'b0, "rand_zero");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
